// File: rtl/led_scan_pkg.sv
// led_scan_pkg
// Shared definitions for the LED scan peripheral: register window offsets,
// CTRL/STATUS bit positions, scan FSM encoding and the step-terminal helper.
package led_scan_pkg;

  // Register offsets inside the 4-address window (port_id[1:0]).
  localparam logic [1:0] OFS_CTRL      = 2'd0;
  localparam logic [1:0] OFS_DIV       = 2'd1;
  localparam logic [1:0] OFS_MAN_SWEEP = 2'd2;
  localparam logic [1:0] OFS_STATUS    = 2'd3;

  // CTRL register bit indices.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_CLR    = 3;

  // STATUS register bit indices; pos occupies bits [2:0].
  localparam int STAT_RUNNING = 7;
  localparam int STAT_DIR     = 6;
  localparam int STAT_IRQ     = 5;

  // CTRL.mode values.
  localparam logic MODE_BOUNCE = 1'b0;
  localparam logic MODE_WRAP   = 1'b1;

  // Scan FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SCAN_UP   = 2'd1,
    ST_SCAN_DOWN = 2'd2
  } scan_state_t;

  // Last step-counter value before a step; DIV=0 behaves as DIV=1.
  function automatic logic [7:0] step_term(input logic [7:0] div);
    return (div == 8'd0) ? 8'd0 : div - 8'd1;
  endfunction

endpackage

// File: rtl/led_scan_timebase.sv
// led_scan_timebase
// Tick prescaler (PRESCALE clk cycles per tick) followed by a step divider
// (max(div,1) ticks per step). Both counters are held at zero while clear=1.
// Ports:
//   clk, reset  clock and asynchronous active-low reset
//   clear       hold both counters at zero, suppress step
//   div         live step period in ticks
//   step        one-cycle pulse on the tick where the step counter is terminal
module led_scan_timebase
  import led_scan_pkg::*;
#(
  parameter int PRESCALE = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [7:0] div,
  output logic       step
);

  localparam int            TW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(PRESCALE - 1);

  logic [TW-1:0] tick_cnt;
  logic [7:0]    step_cnt;
  logic          tick;

  assign tick = !clear && (tick_cnt == TICK_LAST);
  // div is compared live: a new terminal below the current count lets the
  // counter run on and wrap through 255 before it matches again.
  assign step = tick && (step_cnt == step_term(div));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      step_cnt <= '0;
    end else if (clear) begin
      tick_cnt <= '0;
      step_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        step_cnt <= step ? 8'd0 : step_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl
// kcpsm6 port-bus peripheral that scans a one-hot LED position in hardware
// (bounce or wrap) and raises a sticky sweep-complete interrupt.
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   port_id         kcpsm6 port address (4-address window at BASE_ADDR)
//   out_port        kcpsm6 write data
//   write_strobe    write qualifier
//   read_strobe     read qualifier (no read side effects defined)
//   in_port         registered read data, valid 1 cycle after port_id
//   interrupt       level interrupt, held until interrupt_ack or CTRL.clr
//   interrupt_ack   kcpsm6 interrupt acknowledge
//   led_out         registered LED drive
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int         N_LEDS    = 4,
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         PRESCALE  = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        port_id,
  input  logic [7:0]        out_port,
  input  logic              write_strobe,
  input  logic              read_strobe,
  output logic [7:0]        in_port,
  output logic              interrupt,
  input  logic              interrupt_ack,
  output logic [N_LEDS-1:0] led_out
);

  localparam logic [2:0] POS_MAX = 3'(N_LEDS - 1);

  // Configuration registers.
  logic              en;
  logic              mode;
  logic              irq_en;
  logic [7:0]        div;
  logic [N_LEDS-1:0] man;

  // Scan and event state.
  scan_state_t state;
  logic [2:0]  pos;
  logic [7:0]  sweep_cnt;
  logic        irq_pending;

  logic       sel;
  logic       wr_ctrl;
  logic       wr_div;
  logic       wr_man;
  logic       clr;
  logic       tb_clear;
  logic       step;
  logic       sweep;
  logic [7:0] rdata;
  logic       unused_read;

  // Reads have no side effects, so the read qualifier is intentionally idle.
  assign unused_read = read_strobe;

  assign sel     = (port_id[7:2] == BASE_ADDR[7:2]);
  assign wr_ctrl = write_strobe && sel && (port_id[1:0] == OFS_CTRL);
  assign wr_div  = write_strobe && sel && (port_id[1:0] == OFS_DIV);
  assign wr_man  = write_strobe && sel && (port_id[1:0] == OFS_MAN_SWEEP);
  assign clr     = wr_ctrl && out_port[CTRL_CLR];

  // Counters stay cleared in IDLE and on the cycle en drops, so a scan
  // always restarts from a fresh tick/step phase.
  assign tb_clear = (state == ST_IDLE) || !en;

  led_scan_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk   (clk),
    .reset (reset),
    .clear (tb_clear),
    .div   (div),
    .step  (step)
  );

  // A sweep completes when the position lands back on 0 by a step.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sweep = 1'b0;
    if (step) begin
      unique case (state)
        ST_SCAN_UP:   sweep = (pos == POS_MAX) && (mode == MODE_WRAP);
        ST_SCAN_DOWN: sweep = (pos == 3'd1);
        default:      sweep = 1'b0;
      endcase
    end
  end

  // Configuration register writes; clr is a pulse and is not stored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en     <= 1'b0;
      mode   <= MODE_BOUNCE;
      irq_en <= 1'b0;
      div    <= 8'd0;
      man    <= '0;
    end else begin
      if (wr_ctrl) begin
        en     <= out_port[CTRL_EN];
        mode   <= out_port[CTRL_MODE];
        irq_en <= out_port[CTRL_IRQ_EN];
      end
      if (wr_div) div <= out_port;
      if (wr_man) man <= out_port[N_LEDS-1:0];
    end
  end

  // Scan FSM with registered LED output; LEDs lag the state/pos by a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      pos     <= 3'd0;
      led_out <= '0;
    end else begin
      led_out <= (state == ST_IDLE) ? man : (N_LEDS'(1) << pos);
      if (!en) begin
        state <= ST_IDLE;
        pos   <= 3'd0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            state <= ST_SCAN_UP;
            pos   <= 3'd0;
          end
          ST_SCAN_UP: begin
            if (step) begin
              if (pos != POS_MAX) begin
                pos <= pos + 3'd1;
              end else if (mode == MODE_WRAP) begin
                pos <= 3'd0;
              end else begin
                pos   <= pos - 3'd1;
                state <= ST_SCAN_DOWN;
              end
            end
          end
          ST_SCAN_DOWN: begin
            if (step) begin
              pos <= pos - 3'd1;
              if (pos == 3'd1) state <= ST_SCAN_UP;
            end
          end
          default: begin
            state <= ST_IDLE;
            pos   <= 3'd0;
          end
        endcase
      end
    end
  end

  // Sweep counter and sticky interrupt. A sweep on the same edge as ack/clr
  // wins: the counter restarts at 1 and the interrupt stays pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sweep_cnt   <= 8'd0;
      irq_pending <= 1'b0;
    end else begin
      if (sweep) begin
        sweep_cnt <= clr ? 8'd1 : sweep_cnt + 8'd1;
      end else if (clr) begin
        sweep_cnt <= 8'd0;
      end

      if (sweep && irq_en) begin
        irq_pending <= 1'b1;
      end else if (interrupt_ack || clr) begin
        irq_pending <= 1'b0;
      end
    end
  end

  assign interrupt = irq_pending;

  // Read mux, decoded from port_id alone; unmapped addresses read 0.
  always_comb begin
    rdata = 8'h00;
    if (sel) begin
      unique case (port_id[1:0])
        OFS_CTRL: begin
          rdata[CTRL_EN]     = en;
          rdata[CTRL_MODE]   = mode;
          rdata[CTRL_IRQ_EN] = irq_en;
        end
        OFS_DIV:       rdata = div;
        OFS_MAN_SWEEP: rdata = sweep_cnt;
        OFS_STATUS: begin
          rdata[STAT_RUNNING] = (state != ST_IDLE);
          rdata[STAT_DIR]     = (state == ST_SCAN_DOWN);
          rdata[STAT_IRQ]     = irq_pending;
          rdata[2:0]          = pos;
        end
        default: rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_port <= 8'h00;
    end else begin
      in_port <= rdata;
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl
// Directed bench for led_scan_ctrl with N_LEDS=4, PRESCALE=4. Inputs change
// on the falling edge; outputs are sampled on the falling edge.
module tb_led_scan_ctrl;

  localparam int         N_LEDS   = 4;
  localparam int         PRESCALE = 4;
  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_DIV    = 8'h01;
  localparam logic [7:0] A_MAN    = 8'h02;
  localparam logic [7:0] A_STAT   = 8'h03;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        port_id;
  logic [7:0]        out_port;
  logic              write_strobe;
  logic              read_strobe;
  logic [7:0]        in_port;
  logic              interrupt;
  logic              interrupt_ack;
  logic [N_LEDS-1:0] led_out;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  led_scan_ctrl #(
    .N_LEDS   (N_LEDS),
    .BASE_ADDR(8'h00),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack),
    .led_out      (led_out)
  );

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    port_id      = addr;
    out_port     = data;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic read_reg(input logic [7:0] addr, output logic [7:0] data);
    @(negedge clk);
    port_id = addr;
    @(negedge clk);
    data = in_port;
  endtask

  task automatic stop_scan();
    write_reg(A_CTRL, 8'h00);
    repeat (2) @(negedge clk);
  endtask

  // Called right after the enabling write: checks led_out and STATUS (irq
  // bit ignored) every cycle for n_seg segments of hold cycles each.
  task automatic watch_scan(input string name, input int n_seg, input int hold,
                            input int ps[9], input int ds[9]);
    logic [N_LEDS-1:0] exp_led;
    logic [7:0]        exp_st;
    int                seg;
    port_id = A_STAT;
    for (int c = 1; c < 2 + n_seg * hold; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        seg     = (c - 2) / hold;
        exp_led = N_LEDS'(1) << ps[seg];
        exp_st  = 8'h80 | (ds[seg] != 0 ? 8'h40 : 8'h00) | 8'(ps[seg]);
        tests_run++;
        if (led_out !== exp_led) begin
          tests_failed++;
          $display("FAIL %s_led c=%0d: got %b expected %b", name, c, led_out, exp_led);
        end
        tests_run++;
        if ((in_port & 8'hDF) !== exp_st) begin
          tests_failed++;
          $display("FAIL %s_status c=%0d: got %h expected %h", name, c, in_port & 8'hDF, exp_st);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b0; port_id = 8'h00; out_port = 8'h00;
    write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({led_out, interrupt, in_port} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got led=%b irq=%b in=%h expected all zero", led_out, interrupt, in_port);
    end
    reset = 1'b1;
    for (int a = 0; a < 4; a++) begin
      read_reg(8'(a), d);
      tests_run++;
      if (d !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_read_%0d: got %h expected 00", a, d);
      end
    end
  endtask

  task automatic test_bounce();
    int ps[9];
    int ds[9];
    logic [7:0] d;
    ps = '{0, 1, 2, 3, 2, 1, 0, 0, 0};
    ds = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    write_reg(A_DIV, 8'h02);
    read_reg(A_DIV, d);
    tests_run++;
    if (d !== 8'h02) begin
      tests_failed++;
      $display("FAIL div_readback: got %h expected 02", d);
    end
    write_reg(A_CTRL, 8'h01);
    watch_scan("bounce", 7, 8, ps, ds);
    read_reg(A_MAN, d);
    tests_run++;
    if (d !== 8'h01) begin
      tests_failed++;
      $display("FAIL bounce_sweep: got %h expected 01", d);
    end
    stop_scan();
  endtask

  task automatic test_wrap();
    int ps[9];
    int ds[9];
    logic [7:0] d;
    ps = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    ds = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    write_reg(A_CTRL, 8'h08);
    write_reg(A_DIV, 8'h01);
    write_reg(A_CTRL, 8'h03);
    watch_scan("wrap", 9, 4, ps, ds);
    read_reg(A_MAN, d);
    tests_run++;
    if (d !== 8'h02) begin
      tests_failed++;
      $display("FAIL wrap_sweep: got %h expected 02", d);
    end
    stop_scan();
  endtask

  task automatic test_div_zero();
    int ps[9];
    int ds[9];
    logic [7:0] d;
    ps = '{0, 1, 2, 3, 0, 0, 0, 0, 0};
    ds = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    write_reg(A_DIV, 8'h00);
    write_reg(A_CTRL, 8'h03);
    watch_scan("div0", 5, 4, ps, ds);
    stop_scan();
    read_reg(8'h10, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL unmapped_10: got %h expected 00", d);
    end
    read_reg(8'h04, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL unmapped_04: got %h expected 00", d);
    end
  endtask

  // Bounce with DIV=1: sweeps land on the edges 25, 49 and 73 after enable.
  task automatic test_irq();
    write_reg(A_CTRL, 8'h08);
    write_reg(A_DIV, 8'h01);
    write_reg(A_CTRL, 8'h05);
    for (int c = 1; c <= 77; c++) begin
      @(negedge clk);
      if (c == 24 || c == 31 || c == 48 || c == 56 || c == 72 || c == 77) begin
        tests_run++;
        if (interrupt !== 1'b0) begin
          tests_failed++;
          $display("FAIL irq_low c=%0d: got %b expected 0", c, interrupt);
        end
      end
      if (c == 25 || c == 30 || c == 49 || c == 55 || c == 73 || c == 76) begin
        tests_run++;
        if (interrupt !== 1'b1) begin
          tests_failed++;
          $display("FAIL irq_high c=%0d: got %b expected 1", c, interrupt);
        end
      end
      if (c == 57 || c == 74) begin
        tests_run++;
        if (in_port !== (c == 57 ? 8'h00 : 8'h01)) begin
          tests_failed++;
          $display("FAIL irq_sweep c=%0d: got %h expected %h", c, in_port, (c == 57 ? 8'h00 : 8'h01));
        end
      end
      if (c == 58) begin
        tests_run++;
        if (in_port !== 8'h05) begin
          tests_failed++;
          $display("FAIL irq_ctrl_read: got %h expected 05", in_port);
        end
      end
      // Stimulus for the following edge.
      interrupt_ack = (c == 30 || c == 48 || c == 76);
      write_strobe  = (c == 55 || c == 72 || c == 74);
      if (c == 55 || c == 72) begin
        port_id = A_CTRL; out_port = 8'h0D;
      end else if (c == 74) begin
        port_id = A_CTRL; out_port = 8'h01;
      end else if (c == 56 || c == 73) begin
        port_id = A_MAN;
      end else if (c == 57) begin
        port_id = A_CTRL;
      end
    end
    interrupt_ack = 1'b0;
    write_strobe  = 1'b0;
    stop_scan();
  endtask

  task automatic test_manual();
    write_reg(A_DIV, 8'h01);
    write_reg(A_MAN, 8'h0A);
    @(negedge clk);
    tests_run++;
    if (led_out !== 4'b1010) begin
      tests_failed++;
      $display("FAIL man_idle: got %b expected 1010", led_out);
    end
    write_reg(A_CTRL, 8'h03);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 2 || c == 10 || c == 12 || c == 13) begin
        tests_run++;
        if (led_out !== (c == 2 ? 4'b0001 : (c == 13 ? 4'b1010 : 4'b0100))) begin
          tests_failed++;
          $display("FAIL man_led c=%0d: got %b", c, led_out);
        end
      end
      if (c == 13) begin
        tests_run++;
        if (in_port !== 8'h00) begin
          tests_failed++;
          $display("FAIL man_status: got %h expected 00", in_port);
        end
      end
      write_strobe = (c == 10);
      if (c == 10) begin
        port_id = A_CTRL; out_port = 8'h00;
      end else if (c == 11) begin
        port_id = A_STAT;
      end
    end
    write_strobe = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] d;
    write_reg(A_CTRL, 8'h08);
    write_reg(A_CTRL, 8'h05);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 26) begin
        tests_run++;
        if (interrupt !== 1'b1) begin
          tests_failed++;
          $display("FAIL mid_pre_irq: got %b expected 1", interrupt);
        end
      end
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({led_out, interrupt, in_port} !== 13'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got led=%b irq=%b in=%h expected all zero", led_out, interrupt, in_port);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int a = 0; a < 4; a++) begin
      read_reg(8'(a), d);
      tests_run++;
      if (d !== 8'h00) begin
        tests_failed++;
        $display("FAIL mid_read_%0d: got %h expected 00", a, d);
      end
    end
    tests_run++;
    if (led_out !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mid_led_after: got %b expected 0000", led_out);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_wrap();
    test_div_zero();
    test_irq();
    test_manual();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- PicoBlaze (kcpsm6) port-bus peripheral that sequences the LED bank in hardware ("Night Rider" scan).
- The processor configures it through OUTPUT/INPUT instructions: enable, mode, step period, manual pattern and interrupt enable.
- The block then steps a one-hot LED position autonomously and raises a sweep-complete interrupt to the processor.
- It replaces direct software bit-banging of the LED port.

Parameters:
- N_LEDS, 4: LED count (2..8); also the width of led_out.
- BASE_ADDR, 8'h00: first port_id of the 4-address register window; must be 4-aligned.
- PRESCALE, 100000: clk cycles per tick (1 ms at 100 MHz); benches use 4.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- port_id  in  8  kcpsm6 port address
- out_port  in  8  kcpsm6 write data
- write_strobe  in  1  kcpsm6 write qualifier
- read_strobe  in  1  kcpsm6 read qualifier (used only for status side effects; none defined, reserved)
- in_port  out  8  registered read data to kcpsm6
- interrupt  out  1  sweep-complete interrupt, level, sticky
- interrupt_ack  in  1  kcpsm6 interrupt acknowledge
- led_out  out  N_LEDS  LED drive

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0 CTRL (W/R):
    - bit0 en
    - bit1 mode (0 = bounce, 1 = wrap)
    - bit2 irq_en
    - bit3 clr: self-clearing, reads 0; clears sweep_cnt and pending interrupt
  - +1 DIV (W/R): 8-bit step period in ticks.
  - +2 (W) MAN: manual LED pattern, low N_LEDS bits. (R) SWEEP: 8-bit sweep_cnt.
  - +3 (R) STATUS: bit7 running, bit6 dir (1 = down), bit5 irq_pending, bits[2:0] pos.
- Writes take effect on the clk edge where write_strobe=1 and port_id matches.
- in_port is registered from port_id every cycle, with no strobe qualification. Data is valid 1 cycle after port_id, which meets the kcpsm6 2-cycle port_id window. Unmapped port_id reads 8'h00.
- Reset values: all registers 0, in_port=0, interrupt=0, led_out=0, FSM=IDLE, pos=0, counters=0.
- Tick counter: 0..PRESCALE-1; tick pulse on the terminal count. It runs only outside IDLE.
- Step counter: counts ticks 0..max(DIV,1)-1 (DIV=0 behaves as 1). A step occurs on the tick where it is terminal. Step period = max(DIV,1)*PRESCALE cycles.
- A DIV change is compared live; if the new terminal is below the current count, the counter continues and wraps at 8 bits. Benches write DIV only while idle.
- FSM states: IDLE, SCAN_UP, SCAN_DOWN.
  - IDLE: led_out = MAN. When en=1, go to SCAN_UP with pos=0 and tick/step counters cleared.
  - SCAN_UP, on step:
    - pos<N_LEDS-1: pos++.
    - pos=N_LEDS-1 and bounce: pos--, go to SCAN_DOWN.
    - pos=N_LEDS-1 and wrap: pos=0, sweep event.
  - SCAN_DOWN, on step: pos--. If the new pos=0, go to SCAN_UP and raise a sweep event.
  - Any state with en=0: go to IDLE next edge, pos=0, counters cleared.
- led_out is registered: one-hot(pos) in a scan state, MAN in IDLE. LEDs follow the state/pos update by 1 cycle. From the enabling write edge, led_out[0]=1 two edges later.
- Sweep event:
  - sweep_cnt++, wrapping 255->0.
  - If irq_en, irq_pending<=1; interrupt = irq_pending.
- Interrupt clear and priority:
  - interrupt_ack=1 or a clr write clears irq_pending.
  - A sweep event in the same cycle as ack/clr wins: pending stays 1, and a clr in that cycle still yields sweep_cnt=1.
  - Clearing irq_en does not clear a pending interrupt.
- Reset asserted mid-scan: immediate asynchronous return to the reset values; led_out=0 while reset=0.

Decomposition:
- Shared package (led_scan_pkg):
  - register offsets (OFS_CTRL=0, OFS_DIV=1, OFS_MAN_SWEEP=2, OFS_STATUS=3)
  - CTRL bit indices
  - FSM state encoding (2-bit localparams)
- One natural sub-module: led_scan_timebase (tick prescaler plus step divider with clear and step pulse output).
- Register file, FSM and interrupt logic stay in the top.

Test Plan:
- Reset with reset=0 mid-run -> led_out=0000, interrupt=0, in_port=8'h00 immediately; all reads return 0 after release.
- PRESCALE=4: write DIV=2, then CTRL=8'h01 -> led_out sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, each held 8 cycles. Read +2 after return to 0001 gives 8'h01; STATUS dir bit toggles at 1000.
- Write CTRL=8'h03 with DIV=1 -> led_out 0001→0010→0100→1000→0001, 4 cycles each. sweep_cnt increments at each 1000→0001.
- Write CTRL=8'h05 -> interrupt rises in the cycle after the sweep event and stays high until interrupt_ack=1. Ack coinciding with the next sweep event -> interrupt stays 1. Write CTRL=8'h0D -> interrupt=0, sweep_cnt=0.
- Write MAN=8'h0A, then CTRL=8'h00 while at pos 2 -> FSM returns to IDLE and led_out=1010 two edges after the write. A read of +3 returns bit7=0, pos=0.
- DIV=0 with en=1 -> steps every PRESCALE cycles, identical to DIV=1. Read of unmapped port_id 8'h10 -> in_port=8'h00.
